// File: rtl/dual_bram_pipe_if.sv
// dual_bram_pipe_if: one access port of the dual-port block RAM.
//
// Signals:
//   en    - access enable; every enabled access is a read
//   we    - per-byte write enables, honoured only with en=1
//   addr  - word address
//   datai - write data
//   datao - registered read data, holds when no new read completes
//   valid - one-cycle pulse marking a datao update
//
// Modports: master drives the request side, slave is the RAM side.
`timescale 1ns/1ps
interface dual_bram_pipe_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned ADDRS  = 12,
    parameter int unsigned BYTES  = DWIDTH / 8
);
    logic              en;
    logic [BYTES-1:0]  we;
    logic [ADDRS-1:0]  addr;
    logic [DWIDTH-1:0] datai;
    logic [DWIDTH-1:0] datao;
    logic              valid;

    modport master (
        output en, we, addr, datai,
        input  datao, valid
    );

    modport slave (
        input  en, we, addr, datai,
        output datao, valid
    );
endinterface

// File: rtl/dual_bram_pipe.sv
// dual_bram_pipe: true dual-port block RAM with byte write enables, selectable
// same-port read-during-write behaviour, optional output register and an
// optional zero-fill clear engine.
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (pipeline and clear engine only,
//           the array itself is never reset)
//   a, b  - access ports (dual_bram_pipe_if.slave)
//   clear - single-cycle zero-fill request
//   busy  - clear engine active; port accesses are ignored while high
//
// Parameters: DWIDTH (multiple of 8), WORDS, ADDRS, BYTES, RDMODE
// (0 read-first, 1 write-first), OREG (0 latency 1, 1 latency 2).
//
// Build option: define MEM_CLEAR_EN to build the clear engine. Without it
// busy is tied low, clear is ignored and the array powers up undefined.
`timescale 1ns/1ps
module dual_bram_pipe #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned WORDS  = 4096,
    parameter int unsigned ADDRS  = $clog2(WORDS),
    parameter int unsigned BYTES  = DWIDTH / 8,
    parameter int unsigned RDMODE = 0,
    parameter int unsigned OREG   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    dual_bram_pipe_if.slave a,
    dual_bram_pipe_if.slave b,
    input  logic            clear,
    output logic            busy
);

    logic [DWIDTH-1:0] mem [WORDS];

    logic              clr_we;
    logic [ADDRS-1:0]  clr_addr;

    logic              a_acc;
    logic              b_acc;
    logic [BYTES-1:0]  a_wr;
    logic [BYTES-1:0]  b_wr;
    logic [DWIDTH-1:0] a_old;
    logic [DWIDTH-1:0] b_old;
    logic [DWIDTH-1:0] a_new;
    logic [DWIDTH-1:0] b_new;
    logic [DWIDTH-1:0] a_rd;
    logic [DWIDTH-1:0] b_rd;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
`ifdef MEM_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [ADDRS-1:0] CNT_LAST = ADDRS'(WORDS - 1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [ADDRS-1:0] cnt_q;
    logic [ADDRS-1:0] cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // A repeated clear request is ignored: the sweep just runs on.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset parks the engine in CLEAR at address 0, so a sweep always
    // follows reset release and an interrupted sweep starts over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_we   = busy & rst_n;
    assign clr_addr = cnt_q;
`else
    logic unused_clear;

    assign unused_clear = clear;
    assign busy         = 1'b0;
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
`endif

    // ------------------------------------------------------------------
    // Port gating: nothing reaches the array while the clear engine owns it
    // ------------------------------------------------------------------
    assign a_acc = a.en & ~busy & rst_n;
    assign b_acc = b.en & ~busy & rst_n;
    assign a_wr  = a_acc ? a.we : '0;
    assign b_wr  = b_acc ? b.we : '0;

    // ------------------------------------------------------------------
    // Array write. Port B lanes are assigned before port A lanes so that on
    // a same-address, same-lane collision port A's value is the one kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (b_wr[k]) begin
                    mem[b.addr][k*8 +: 8] <= b.datai[k*8 +: 8];
                end
                if (a_wr[k]) begin
                    mem[a.addr][k*8 +: 8] <= a.datai[k*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data. Write-first merges only this port's own write lanes; the
    // other port's write in the same cycle is never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        a_old = mem[a.addr];
        b_old = mem[b.addr];
        a_new = a_old;
        b_new = b_old;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (a_wr[k]) begin
                a_new[k*8 +: 8] = a.datai[k*8 +: 8];
            end
            if (b_wr[k]) begin
                b_new[k*8 +: 8] = b.datai[k*8 +: 8];
            end
        end
        a_rd = (RDMODE != 0) ? a_new : a_old;
        b_rd = (RDMODE != 0) ? b_new : b_old;
    end

    // ------------------------------------------------------------------
    // First read stage: captures data only on an accepted access so the
    // output holds while a port is idle.
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] a_s1_data;
    logic [DWIDTH-1:0] b_s1_data;
    logic              a_s1_valid;
    logic              b_s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_data  <= '0;
            b_s1_data  <= '0;
            a_s1_valid <= 1'b0;
            b_s1_valid <= 1'b0;
        end else begin
            a_s1_valid <= a_acc;
            b_s1_valid <= b_acc;
            if (a_acc) begin
                a_s1_data <= a_rd;
            end
            if (b_acc) begin
                b_s1_data <= b_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output register. It is not gated by busy, so reads accepted
    // before a clear started still drain out.
    // ------------------------------------------------------------------
    if (OREG != 0) begin : g_oreg
        logic [DWIDTH-1:0] a_s2_data;
        logic [DWIDTH-1:0] b_s2_data;
        logic              a_s2_valid;
        logic              b_s2_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_s2_data  <= '0;
                b_s2_data  <= '0;
                a_s2_valid <= 1'b0;
                b_s2_valid <= 1'b0;
            end else begin
                a_s2_valid <= a_s1_valid;
                b_s2_valid <= b_s1_valid;
                if (a_s1_valid) begin
                    a_s2_data <= a_s1_data;
                end
                if (b_s1_valid) begin
                    b_s2_data <= b_s1_data;
                end
            end
        end

        assign a.datao = a_s2_data;
        assign a.valid = a_s2_valid;
        assign b.datao = b_s2_data;
        assign b.valid = b_s2_valid;
    end else begin : g_no_oreg
        assign a.datao = a_s1_data;
        assign a.valid = a_s1_valid;
        assign b.datao = b_s1_data;
        assign b.valid = b_s1_valid;
    end

endmodule

// File: tb/tb_dual_bram_pipe.sv
// Self-checking bench for dual_bram_pipe. Two instances share one stimulus
// stream: dut0 is read-first with the output register, dut1 is write-first
// without it. A reference array predicts every read; expectations are queued
// per instance/port with the cycle they are due and checked when valid rises.
`timescale 1ns/1ps
module tb_dual_bram_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned NW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned NB = 4;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
        bit            chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic busy0;
    logic busy1;

    logic          a_en = 1'b0;
    logic          b_en = 1'b0;
    logic [NB-1:0] a_we = '0;
    logic [NB-1:0] b_we = '0;
    logic [AW-1:0] a_addr = '0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] a_di = '0;
    logic [DW-1:0] b_di = '0;

    int unsigned cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          mdl_busy = 1'b0;

    logic [DW-1:0] ref_mem [NW];
    logic [NB-1:0] ref_kb [NW];
    exp_t          sb [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_bram_pipe_if #(.DWIDTH(DW), .ADDRS(AW), .BYTES(NB)) a0_if ();
    dual_bram_pipe_if #(.DWIDTH(DW), .ADDRS(AW), .BYTES(NB)) b0_if ();
    dual_bram_pipe_if #(.DWIDTH(DW), .ADDRS(AW), .BYTES(NB)) a1_if ();
    dual_bram_pipe_if #(.DWIDTH(DW), .ADDRS(AW), .BYTES(NB)) b1_if ();

    assign a0_if.en = a_en;
    assign a0_if.we = a_we;
    assign a0_if.addr = a_addr;
    assign a0_if.datai = a_di;
    assign b0_if.en = b_en;
    assign b0_if.we = b_we;
    assign b0_if.addr = b_addr;
    assign b0_if.datai = b_di;
    assign a1_if.en = a_en;
    assign a1_if.we = a_we;
    assign a1_if.addr = a_addr;
    assign a1_if.datai = a_di;
    assign b1_if.en = b_en;
    assign b1_if.we = b_we;
    assign b1_if.addr = b_addr;
    assign b1_if.datai = b_di;

    dual_bram_pipe #(.DWIDTH(DW), .WORDS(NW), .RDMODE(0), .OREG(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a0_if), .b(b0_if), .clear(clear), .busy(busy0)
    );

    dual_bram_pipe #(.DWIDTH(DW), .WORDS(NW), .RDMODE(1), .OREG(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1_if), .b(b1_if), .clear(clear), .busy(busy1)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [NB-1:0] we,
                                            input logic [DW-1:0] n);
        logic [DW-1:0] r;
        r = o;
        for (int k = 0; k < NB; k++) begin
            if (we[k]) r[k*8 +: 8] = n[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic push(input int idx, input logic [DW-1:0] d, input int unsigned due,
                        input bit chk);
        exp_t e;
        e.data = d;
        e.due = due;
        e.chk = chk;
        sb[idx].push_back(e);
    endtask

    // Drive one cycle of stimulus now and predict its outputs.
    task automatic drive_now(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aad,
                             input logic [DW-1:0] ad, input logic be, input logic [NB-1:0] bwe,
                             input logic [AW-1:0] bad, input logic [DW-1:0] bd);
        logic [DW-1:0] oa;
        logic [DW-1:0] ob;
        a_en = ae; a_we = awe; a_addr = aad; a_di = ad;
        b_en = be; b_we = bwe; b_addr = bad; b_di = bd;
        if (!mdl_busy) begin
            oa = ref_mem[aad];
            ob = ref_mem[bad];
            if (ae) begin
                push(0, oa, cyc + 2, &ref_kb[aad]);
                push(2, merge(oa, awe, ad), cyc + 1, &(ref_kb[aad] | awe));
            end
            if (be) begin
                push(1, ob, cyc + 2, &ref_kb[bad]);
                push(3, merge(ob, bwe, bd), cyc + 1, &(ref_kb[bad] | bwe));
            end
            if (be) begin
                ref_mem[bad] = merge(ref_mem[bad], bwe, bd);
                ref_kb[bad] = ref_kb[bad] | bwe;
            end
            if (ae) begin
                ref_mem[aad] = merge(ref_mem[aad], awe, ad);
                ref_kb[aad] = ref_kb[aad] | awe;
            end
        end
    endtask

    task automatic acc(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aad,
                       input logic [DW-1:0] ad, input logic be, input logic [NB-1:0] bwe,
                       input logic [AW-1:0] bad, input logic [DW-1:0] bd);
        @(negedge clk);
        drive_now(ae, awe, aad, ad, be, bwe, bad, bd);
    endtask

    task automatic idle(input int n);
        repeat (n) acc(0, '0, '0, '0, 0, '0, '0, '0);
    endtask

    task automatic mon(input int idx, input logic v, input logic [DW-1:0] d);
        exp_t e;
        if (v) begin
            tests_run++;
            if (sb[idx].size() == 0) begin
                tests_failed++;
                $display("FAIL sb%0d_unexpected_valid: got data %h at cycle %0d, required no output",
                         idx, d, cyc);
            end else begin
                e = sb[idx].pop_front();
                if (cyc != e.due) begin
                    tests_failed++;
                    $display("FAIL sb%0d_latency: got output at cycle %0d, required cycle %0d",
                             idx, cyc, e.due);
                end else if (e.chk && d !== e.data) begin
                    tests_failed++;
                    $display("FAIL sb%0d_data: got %h, required %h (cycle %0d)",
                             idx, d, e.data, cyc);
                end
            end
        end
        if (sb[idx].size() != 0 && sb[idx][0].due < cyc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb%0d_missing: got no output by cycle %0d, required %h at cycle %0d",
                     idx, cyc, sb[idx][0].data, sb[idx][0].due);
            void'(sb[idx].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, a0_if.valid, a0_if.datao);
        mon(1, b0_if.valid, b0_if.datao);
        mon(2, a1_if.valid, a1_if.datao);
        mon(3, b1_if.valid, b1_if.datao);
    end

    task automatic check_reset_outputs(input string tag);
        logic [DW-1:0] dv [4];
        logic          vv [4];
        dv = '{a0_if.datao, b0_if.datao, a1_if.datao, b1_if.datao};
        vv = '{a0_if.valid, b0_if.valid, a1_if.valid, b1_if.valid};
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (dv[i] !== '0 || vv[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_out%0d: got datao=%h valid=%b, required datao=0 valid=0",
                         tag, i, dv[i], vv[i]);
            end
        end
    endtask

    task automatic check_busy(input string tag, input logic exp_b);
        tests_run++;
        if (busy0 !== exp_b || busy1 !== exp_b) begin
            tests_failed++;
            $display("FAIL %s_busy: got %b/%b, required %b", tag, busy0, busy1, exp_b);
        end
    endtask

    task automatic check_hold(input string tag, input logic [DW-1:0] got,
                              input logic [DW-1:0] exp_d);
        tests_run++;
        if (got !== exp_d) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", tag, got, exp_d);
        end
    endtask

    // Wait for busy to drop after reset release; returns edges counted.
    task automatic count_sweep(output int n, input bit traffic);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (traffic && n <= 10) begin
                drive_now(1, 4'hF, AW'(n), 32'h5A5A_0000 + n, 1, 4'hF, AW'(n + 3), 32'hC3C3_C3C3);
            end else begin
                drive_now(0, '0, '0, '0, 0, '0, '0, '0);
            end
        end while ((busy0 || busy1) && n < 64);
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < NW; i++) begin
            ref_mem[i] = '0;
            ref_kb[i] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
`ifdef MEM_CLEAR_EN
        check_busy("reset", 1'b1);
        mdl_busy = 1'b1;
        rst_n = 1'b1;
        count_sweep(n, 1'b0);
        tests_run++;
        if (n != NW) begin
            tests_failed++;
            $display("FAIL reset_sweep_len: got busy for %0d edges, required %0d", n, NW);
        end
        mdl_busy = 1'b0;
        for (int i = 0; i < NW; i++) ref_kb[i] = '1;
        for (int i = 0; i < NW; i++) acc(1, '0, AW'(i), '0, 1, '0, AW'(NW - 1 - i), '0);
        idle(3);
`else
        check_busy("reset", 1'b0);
        rst_n = 1'b1;
        // First edge after release already accepts a write.
        drive_now(1, 4'hF, 4'd0, 32'h0BAD_F00D, 0, '0, '0, '0);
        @(negedge clk);
        check_busy("post_reset", 1'b0);
        drive_now(1, '0, 4'd0, '0, 1, '0, 4'd0, '0);
        idle(3);
        check_hold("first_cycle_rd", a0_if.datao, 32'h0BAD_F00D);
`endif
    endtask

    task automatic test_byte_we();
        acc(1, 4'b1111, 4'd5, 32'hDEAD_BEEF, 0, '0, '0, '0);
        acc(1, 4'b0101, 4'd5, 32'h1122_3344, 0, '0, '0, '0);
        acc(1, 4'b0000, 4'd5, '0, 0, '0, '0, '0);
        idle(3);
        check_hold("byte_we_hold0", a0_if.datao, 32'hDE22_BE44);
        check_hold("byte_we_hold1", a1_if.datao, 32'hDE22_BE44);
    endtask

    task automatic test_rdw();
        acc(1, 4'hF, 4'd3, 32'h5555_5555, 0, '0, '0, '0);
        acc(1, 4'hF, 4'd3, 32'hAAAA_AAAA, 1, '0, 4'd3, '0);
        idle(3);
        check_hold("rdw_a_readfirst", a0_if.datao, 32'h5555_5555);
        check_hold("rdw_a_writefirst", a1_if.datao, 32'hAAAA_AAAA);
        check_hold("rdw_b_cross0", b0_if.datao, 32'h5555_5555);
        check_hold("rdw_b_cross1", b1_if.datao, 32'h5555_5555);
    endtask

    task automatic test_collision();
        acc(1, 4'hF, 4'd6, 32'h3333_3333, 0, '0, '0, '0);
        acc(1, 4'hF, 4'd7, 32'h0102_0304, 1, 4'hF, 4'd7, 32'hA0B0_C0D0);
        acc(1, 4'b0011, 4'd6, 32'h1111_1111, 1, 4'b0110, 4'd6, 32'h2222_2222);
        acc(0, '0, '0, '0, 1, '0, 4'd7, '0);
        acc(1, '0, 4'd6, '0, 0, '0, '0, '0);
        idle(3);
        check_hold("collide_full0", b0_if.datao, 32'h0102_0304);
        check_hold("collide_full1", b1_if.datao, 32'h0102_0304);
        check_hold("collide_lanes0", a0_if.datao, 32'h3322_1111);
        check_hold("collide_lanes1", a1_if.datao, 32'h3322_1111);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            acc(1, '0, AW'(i), '0, 1, 4'hF, AW'(8 + i), $urandom());
        end
        for (int i = 0; i < 8; i++) begin
            acc(1, '0, AW'(8 + i), '0, 1, '0, AW'(15 - i), '0);
        end
        idle(3);
    endtask

`ifdef MEM_CLEAR_EN
    task automatic test_clear_engine();
        int n;
        acc(1, 4'hF, 4'd2, 32'h1234_5678, 1, 4'hF, 4'd9, 32'h9ABC_DEF0);
        @(negedge clk);
        clear = 1'b1;
        // Accepted: busy is still low at the edge that samples clear.
        drive_now(1, '0, 4'd2, '0, 1, 4'hF, 4'd4, 32'hCAFE_BABE);
        mdl_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clear = (i == 3);
            check_busy("clear_active", 1'b1);
            drive_now(1, 4'hF, AW'(i), 32'hFFFF_FFFF, 1, 4'hF, AW'(15 - i), 32'hEEEE_EEEE);
        end
        // The sweep has written addresses 0..7; abort it with a reset pulse.
        @(negedge clk);
        clear = 1'b0;
        rst_n = 1'b0;
        drive_now(0, '0, '0, '0, 0, '0, '0, '0);
        @(negedge clk);
        check_busy("mid_clear_reset", 1'b1);
        check_reset_outputs("mid_clear_reset");
        rst_n = 1'b1;
        count_sweep(n, 1'b1);
        tests_run++;
        if (n != NW) begin
            tests_failed++;
            $display("FAIL restart_sweep_len: got busy for %0d edges, required %0d", n, NW);
        end
        mdl_busy = 1'b0;
        for (int i = 0; i < NW; i++) begin
            ref_mem[i] = '0;
            ref_kb[i] = '1;
        end
        for (int i = 0; i < NW; i++) acc(1, '0, AW'(i), '0, 1, '0, AW'(NW - 1 - i), '0);
        idle(3);
    endtask
`else
    task automatic test_no_clear();
        @(negedge clk);
        clear = 1'b1;
        drive_now(1, 4'hF, 4'd2, 32'h1111_2222, 0, '0, '0, '0);
        @(negedge clk);
        clear = 1'b0;
        check_busy("no_clear_1", 1'b0);
        drive_now(1, '0, 4'd2, '0, 1, '0, 4'd2, '0);
        @(negedge clk);
        check_busy("no_clear_2", 1'b0);
        drive_now(0, '0, '0, '0, 0, '0, '0, '0);
        idle(3);
        check_hold("no_clear_data", b0_if.datao, 32'h1111_2222);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no summary by 2 ms, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_byte_we();
        test_rdw();
        test_collision();
        test_back_to_back();
`ifdef MEM_CLEAR_EN
        test_clear_engine();
`else
        test_no_clear();
`endif
        idle(4);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (sb[i].size() != 0) begin
                tests_failed++;
                $display("FAIL sb%0d_drain: got %0d pending reads, required 0", i, sb[i].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
